// File: rtl/flght_cntrl_pid_if.sv
// Bundles the inertial/command inputs and motor-speed outputs of the PID flight controller.
// master drives samples and commands; slave is the controller producing motor speeds.
interface flght_cntrl_pid_if;
    logic               vld;
    logic               arm;
    logic               inertial_cal;
    logic signed [15:0] d_ptch;
    logic signed [15:0] d_roll;
    logic signed [15:0] d_yaw;
    logic signed [15:0] ptch;
    logic signed [15:0] roll;
    logic signed [15:0] yaw;
    logic [8:0]         thrst;
    logic [10:0]        frnt_spd;
    logic [10:0]        bck_spd;
    logic [10:0]        lft_spd;
    logic [10:0]        rght_spd;
    logic               spd_vld;
    logic [1:0]         fsm_state;

    modport master (
        output vld, arm, inertial_cal, d_ptch, d_roll, d_yaw, ptch, roll, yaw, thrst,
        input  frnt_spd, bck_spd, lft_spd, rght_spd, spd_vld, fsm_state
    );

    modport slave (
        input  vld, arm, inertial_cal, d_ptch, d_roll, d_yaw, ptch, roll, yaw, thrst,
        output frnt_spd, bck_spd, lft_spd, rght_spd, spd_vld, fsm_state
    );
endinterface

// File: rtl/flght_cntrl_pid.sv
// Per-axis PID (P, clamped I, delayed D) mixed with thrust into four motor speeds, gated by an arm/cal/ramp FSM.
// Latency: sample vld -> err_sat next edge -> speeds + spd_vld the edge after; accepts one sample per cycle, no backpressure.
module flght_cntrl_pid #(
    parameter int          D_QUEUE_DEPTH = 14,
    parameter int          D_COEFF       = 7,
    parameter int          I_SHIFT       = 6,
    parameter int          I_LIM         = 8191,
    parameter logic [10:0] CAL_SPEED     = 11'h1B0,
    parameter logic [12:0] MIN_RUN_SPEED = 13'h200,
    parameter int          RAMP_STEP     = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    flght_cntrl_pid_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CAL  = 2'd1,
        RAMP = 2'd2,
        RUN  = 2'd3
    } state_t;

    localparam logic signed [16:0] ILIM_P   = 17'(I_LIM);
    localparam logic signed [16:0] ILIM_N   = -17'(I_LIM);
    localparam logic signed [15:0] DCOEF    = 16'(D_COEFF);
    localparam logic [11:0]        CAP_INIT = {1'b0, CAL_SPEED};
    localparam logic [11:0]        CAP_STEP = 12'(RAMP_STEP);
    localparam logic [11:0]        CAP_DONE = 12'd2047;

    state_t             state_q;
    state_t             state_d;
    logic               vld_d1;
    logic [11:0]        cap;

    logic signed [15:0] meas       [3];
    logic signed [15:0] des        [3];
    logic signed [9:0]  err_nxt    [3];
    logic signed [9:0]  err_sat    [3];
    logic signed [9:0]  dq         [3][D_QUEUE_DEPTH];
    logic signed [15:0] integ      [3];
    logic signed [16:0] integ_sum  [3];
    logic signed [15:0] integ_nxt  [3];
    logic signed [15:0] e16        [3];
    logic signed [15:0] pterm      [3];
    logic signed [10:0] ddiff      [3];
    logic signed [5:0]  dsat       [3];
    logic signed [15:0] dterm      [3];
    logic signed [15:0] ax         [3];
    logic signed [15:0] base;
    logic signed [15:0] mix        [4];
    logic [10:0]        mix_sat    [4];
    logic [10:0]        ramp_spd   [4];
    logic [10:0]        spd        [4];
    logic               spd_vld_q;

    assign meas[0] = bus.ptch;
    assign meas[1] = bus.roll;
    assign meas[2] = bus.yaw;
    assign des[0]  = bus.d_ptch;
    assign des[1]  = bus.d_roll;
    assign des[2]  = bus.d_yaw;

    function automatic logic signed [9:0] sat10(input logic signed [16:0] v);
        logic signed [9:0] r;
        if (v > 17'sd511)
            r = 10'sd511;
        else if (v < -17'sd512)
            r = 10'sh200;
        else
            r = v[9:0];
        return r;
    endfunction

    function automatic logic signed [5:0] sat6(input logic signed [10:0] v);
        logic signed [5:0] r;
        if (v > 11'sd31)
            r = 6'sd31;
        else if (v < -11'sd32)
            r = 6'sh20;
        else
            r = v[5:0];
        return r;
    endfunction

    function automatic logic [10:0] sat11(input logic signed [15:0] v);
        logic [10:0] r;
        if (v < 16'sd0)
            r = 11'd0;
        else if (v > 16'sd2047)
            r = 11'h7FF;
        else
            r = v[10:0];
        return r;
    endfunction

    // Error saturation and the clamped integrator step both use the sample being accepted.
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            err_nxt[i]   = sat10($signed({meas[i][15], meas[i]}) - $signed({des[i][15], des[i]}));
            integ_sum[i] = $signed({integ[i][15], integ[i]}) + $signed({{7{err_nxt[i][9]}}, err_nxt[i]});
            if (integ_sum[i] > ILIM_P)
                integ_nxt[i] = ILIM_P[15:0];
            else if (integ_sum[i] < ILIM_N)
                integ_nxt[i] = ILIM_N[15:0];
            else
                integ_nxt[i] = integ_sum[i][15:0];
        end
    end

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            e16[i]   = $signed({{6{err_sat[i][9]}}, err_sat[i]});
            pterm[i] = (e16[i] >>> 1) + (e16[i] >>> 3);
            ddiff[i] = $signed({err_sat[i][9], err_sat[i]})
                     - $signed({dq[i][D_QUEUE_DEPTH-1][9], dq[i][D_QUEUE_DEPTH-1]});
            dsat[i]  = sat6(ddiff[i]);
            dterm[i] = $signed({{10{dsat[i][5]}}, dsat[i]}) * DCOEF;
            ax[i]    = pterm[i] + dterm[i] + (integ[i] >>> I_SHIFT);
        end
    end

    always_comb begin
        base   = $signed({7'd0, bus.thrst}) + $signed({3'd0, MIN_RUN_SPEED});
        mix[0] = base - ax[0] - ax[2];
        mix[1] = base + ax[0] - ax[2];
        mix[2] = base - ax[1] + ax[2];
        mix[3] = base + ax[1] + ax[2];
        for (int m = 0; m < 4; m++) begin
            mix_sat[m]  = sat11(mix[m]);
            ramp_spd[m] = ({1'b0, mix_sat[m]} > cap) ? cap[10:0] : mix_sat[m];
        end
    end

    // Disarm overrides everything; calibration request overrides ramp completion.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = bus.inertial_cal ? CAL : RAMP;
            CAL:     if (!bus.inertial_cal) state_d = RAMP;
            RAMP: begin
                if (bus.inertial_cal)
                    state_d = CAL;
                else if (cap >= CAP_DONE)
                    state_d = RUN;
            end
            RUN:     if (bus.inertial_cal) state_d = CAL;
            default: state_d = IDLE;
        endcase
        if (!bus.arm)
            state_d = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            vld_d1  <= 1'b0;
        end else begin
            state_q <= state_d;
            vld_d1  <= bus.vld;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) begin
                err_sat[i] <= '0;
                integ[i]   <= '0;
                for (int j = 0; j < D_QUEUE_DEPTH; j++)
                    dq[i][j] <= '0;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (bus.vld)
                    err_sat[i] <= err_nxt[i];

                if (state_d == IDLE) begin
                    for (int j = 0; j < D_QUEUE_DEPTH; j++)
                        dq[i][j] <= '0;
                end else if (bus.vld) begin
                    dq[i][0] <= err_sat[i];
                    for (int j = 1; j < D_QUEUE_DEPTH; j++)
                        dq[i][j] <= dq[i][j-1];
                end

                if (state_q != RUN || state_d == IDLE)
                    integ[i] <= '0;
                else if (bus.vld)
                    integ[i] <= integ_nxt[i];
            end
        end
    end

    // Output muxing follows the state being entered, so disarm/cal take effect on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cap       <= CAP_INIT;
            spd_vld_q <= 1'b0;
            for (int m = 0; m < 4; m++)
                spd[m] <= '0;
        end else begin
            spd_vld_q <= vld_d1 && (state_d == RAMP || state_d == RUN);

            if (state_d == IDLE || state_d == CAL)
                cap <= CAP_INIT;
            else if (state_d == RAMP && vld_d1)
                cap <= cap + CAP_STEP;

            for (int m = 0; m < 4; m++) begin
                case (state_d)
                    IDLE:    spd[m] <= '0;
                    CAL:     spd[m] <= CAL_SPEED;
                    RAMP:    if (vld_d1) spd[m] <= ramp_spd[m];
                    RUN:     if (vld_d1) spd[m] <= mix_sat[m];
                    default: spd[m] <= '0;
                endcase
            end
        end
    end

    assign bus.frnt_spd  = spd[0];
    assign bus.bck_spd   = spd[1];
    assign bus.lft_spd   = spd[2];
    assign bus.rght_spd  = spd[3];
    assign bus.spd_vld   = spd_vld_q;
    assign bus.fsm_state = state_q;

endmodule

// File: tb/tb_flght_cntrl_pid.sv
// Bench for flght_cntrl_pid: hand-derived vector table and directed PID sequences, then random traffic vs. a reference model.
module tb_flght_cntrl_pid;
    logic clk = 1'b0;
    logic rst_n = 1'b0;

    flght_cntrl_pid_if bus ();

    flght_cntrl_pid dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_model = 1'b0;

    typedef struct {
        bit arm;
        bit cal;
        bit vld;
        int thr;
        int st;
        int spd;
        bit sv;
    } vec_t;

    vec_t tbl [14];

    // Reference model state (plain integers, speeds indexed frnt/bck/lft/rght)
    int m_state, m_cap, m_pend, m_sv;
    int m_err   [3];
    int m_integ [3];
    int m_spd   [4];
    int m_hist  [3][$];

    function automatic int fdiv(int a, int b);
        int q;
        q = a / b;
        if ((a % b != 0) && (a < 0))
            q = q - 1;
        return q;
    endfunction

    function automatic int clampi(int v, int lo, int hi);
        return (v < lo) ? lo : ((v > hi) ? hi : v);
    endfunction

    task automatic model_reset();
        m_state = 0; m_cap = 432; m_pend = 0; m_sv = 0;
        for (int i = 0; i < 3; i++) begin
            m_err[i] = 0; m_integ[i] = 0;
            m_hist[i].delete();
            for (int j = 0; j < 14; j++) m_hist[i].push_back(0);
        end
        for (int m = 0; m < 4; m++) m_spd[m] = 0;
    endtask

    task automatic model_step();
        int nst, base, e_new;
        int ax  [3];
        int mix [4];
        int me  [3];
        int de  [3];
        me[0] = bus.ptch;   me[1] = bus.roll;   me[2] = bus.yaw;
        de[0] = bus.d_ptch; de[1] = bus.d_roll; de[2] = bus.d_yaw;

        if (!bus.arm) nst = 0;
        else if (bus.inertial_cal) nst = 1;
        else if (m_state == 2 && m_cap >= 2047) nst = 3;
        else if (m_state == 3) nst = 3;
        else nst = 2;

        for (int i = 0; i < 3; i++)
            ax[i] = fdiv(m_err[i], 2) + fdiv(m_err[i], 8)
                  + 7 * clampi(m_err[i] - m_hist[i][13], -32, 31)
                  + fdiv(m_integ[i], 64);
        base = int'(bus.thrst) + 512;
        mix[0] = base - ax[0] - ax[2];
        mix[1] = base + ax[0] - ax[2];
        mix[2] = base - ax[1] + ax[2];
        mix[3] = base + ax[1] + ax[2];

        m_sv = 0;
        if (nst == 0) begin
            for (int m = 0; m < 4; m++) m_spd[m] = 0;
        end else if (nst == 1) begin
            for (int m = 0; m < 4; m++) m_spd[m] = 432;
        end else if (m_pend != 0) begin
            m_sv = 1;
            for (int m = 0; m < 4; m++) begin
                m_spd[m] = clampi(mix[m], 0, 2047);
                if (nst == 2 && m_spd[m] > m_cap) m_spd[m] = m_cap;
            end
        end

        if (nst <= 1) m_cap = 432;
        else if (nst == 2 && m_pend != 0) m_cap += 8;

        if (bus.vld) begin
            for (int i = 0; i < 3; i++) begin
                e_new = clampi(me[i] - de[i], -512, 511);
                if (m_state == 3) m_integ[i] = clampi(m_integ[i] + e_new, -8191, 8191);
                m_hist[i].push_front(m_err[i]);
                void'(m_hist[i].pop_back());
                m_err[i] = e_new;
            end
        end
        for (int i = 0; i < 3; i++) begin
            if (m_state != 3 || nst == 0) m_integ[i] = 0;
            if (nst == 0)
                for (int j = 0; j < 14; j++) m_hist[i][j] = 0;
        end
        m_pend = bus.vld ? 1 : 0;
        m_state = nst;
    endtask

    task automatic chk(string nm, int act, int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic chk_spd(string nm, int f, int b, int l, int r);
        chk({nm, ".frnt"}, int'(bus.frnt_spd), f);
        chk({nm, ".bck"},  int'(bus.bck_spd),  b);
        chk({nm, ".lft"},  int'(bus.lft_spd),  l);
        chk({nm, ".rght"}, int'(bus.rght_spd), r);
    endtask

    task automatic compare_model();
        chk("mdl.state", int'(bus.fsm_state), m_state);
        chk("mdl.spd_vld", int'(bus.spd_vld), m_sv);
        chk_spd("mdl", m_spd[0], m_spd[1], m_spd[2], m_spd[3]);
    endtask

    task automatic cyc();
        model_step();
        @(posedge clk);
        #1;
        if (chk_model) compare_model();
    endtask

    task automatic set_err(int ep, int er, int ey);
        int b;
        b = int'($urandom_range(0, 20000)) - 10000;
        bus.d_ptch = 16'(b); bus.ptch = 16'(b + ep);
        b = int'($urandom_range(0, 20000)) - 10000;
        bus.d_roll = 16'(b); bus.roll = 16'(b + er);
        b = int'($urandom_range(0, 20000)) - 10000;
        bus.d_yaw = 16'(b);  bus.yaw = 16'(b + ey);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        #12;
        rst_n = 1'b1;
    endtask

    initial begin
        bus.vld = 0; bus.arm = 0; bus.inertial_cal = 0; bus.thrst = '0;
        set_err(0, 0, 0);
        model_reset();

        //        arm cal vld thr  st spd  sv
        tbl[0]  = '{0, 0, 1, 0,   0, 0,   0};
        tbl[1]  = '{0, 0, 1, 0,   0, 0,   0};
        tbl[2]  = '{0, 0, 1, 0,   0, 0,   0};
        tbl[3]  = '{1, 1, 0, 0,   1, 432, 0};
        tbl[4]  = '{1, 1, 1, 0,   1, 432, 0};
        tbl[5]  = '{1, 1, 0, 0,   1, 432, 0};
        tbl[6]  = '{1, 0, 0, 0,   2, 432, 0};
        tbl[7]  = '{1, 0, 1, 511, 2, 432, 0};
        tbl[8]  = '{1, 0, 1, 511, 2, 432, 1};
        tbl[9]  = '{1, 0, 1, 511, 2, 440, 1};
        tbl[10] = '{1, 0, 1, 511, 2, 448, 1};
        tbl[11] = '{1, 0, 0, 511, 2, 456, 1};
        tbl[12] = '{1, 0, 0, 511, 2, 456, 0};
        tbl[13] = '{0, 0, 0, 511, 0, 0,   0};

        #2;
        chk("rst.state", int'(bus.fsm_state), 0);
        chk("rst.spd_vld", int'(bus.spd_vld), 0);
        chk_spd("rst", 0, 0, 0, 0);
        #10;
        rst_n = 1'b1;

        for (int k = 0; k < 14; k++) begin
            bus.arm = tbl[k].arm; bus.inertial_cal = tbl[k].cal; bus.vld = tbl[k].vld;
            bus.thrst = 9'(tbl[k].thr);
            set_err(0, 0, 0);
            cyc();
            chk($sformatf("tbl%0d.state", k), int'(bus.fsm_state), tbl[k].st);
            chk($sformatf("tbl%0d.spd_vld", k), int'(bus.spd_vld), int'(tbl[k].sv));
            chk_spd($sformatf("tbl%0d", k), tbl[k].spd, tbl[k].spd, tbl[k].spd, tbl[k].spd);
        end

        // Ramp straight from IDLE to RUN with zero error
        bus.arm = 1; bus.inertial_cal = 0; bus.vld = 1; bus.thrst = 9'd511;
        for (int k = 0; k < 400 && bus.fsm_state != 2'd3; k++) begin
            set_err(0, 0, 0);
            cyc();
        end
        chk("ramp_to_run", int'(bus.fsm_state), 3);
        for (int k = 0; k < 3; k++) cyc();
        bus.vld = 0; cyc(); cyc();
        chk("run.state", int'(bus.fsm_state), 3);
        chk_spd("run.idle_err", 1023, 1023, 1023, 1023);

        // Single pitch step of +100
        set_err(100, 0, 0); bus.vld = 1; cyc();
        bus.vld = 0; cyc();
        chk("step.spd_vld", int'(bus.spd_vld), 1);
        chk_spd("step", 743, 1303, 1023, 1023);
        cyc();
        chk("step.spd_vld_drop", int'(bus.spd_vld), 0);

        // Integrator wind-up against the clamp, using the 17-bit error extreme
        set_err(0, 0, 0);
        bus.ptch = 16'sh7FFF; bus.d_ptch = 16'sh8000; bus.vld = 1;
        for (int k = 0; k < 1000; k++) cyc();
        bus.vld = 0; cyc();
        chk_spd("windup", 578, 1468, 1023, 1023);
        set_err(0, 0, 0); bus.vld = 1;
        for (int k = 0; k < 20; k++) cyc();
        bus.vld = 0; cyc();
        chk_spd("iterm_hold", 896, 1150, 1023, 1023);

        // Output saturation at both ends, then disarm
        set_err(0, 0, 0); bus.thrst = 9'd0;
        bus.roll = 16'sh8000; bus.d_roll = 16'sh7FFF; bus.vld = 1; cyc();
        bus.vld = 0; cyc();
        chk_spd("sat_low", 385, 639, 1064, 0);
        bus.thrst = 9'd511; bus.yaw = 16'sd600; bus.d_yaw = 16'sd89; bus.vld = 1; cyc();
        bus.vld = 0; cyc();
        chk_spd("sat_high", 354, 608, 2047, 1005);
        bus.arm = 0; cyc();
        chk("disarm.state", int'(bus.fsm_state), 0);
        chk("disarm.spd_vld", int'(bus.spd_vld), 0);
        chk_spd("disarm", 0, 0, 0, 0);

        // Random traffic against the reference model, with one mid-run asynchronous reset
        do_reset();
        chk_model = 1'b1;
        bus.arm = 1; bus.inertial_cal = 0;
        for (int c = 0; c < 6000; c++) begin
            if (bus.arm) bus.arm = ($urandom_range(0, 1999) != 0);
            else         bus.arm = ($urandom_range(0, 3) == 0);
            if (bus.inertial_cal) bus.inertial_cal = ($urandom_range(0, 7) != 0);
            else                  bus.inertial_cal = ($urandom_range(0, 1499) == 0);
            bus.vld = ($urandom_range(0, 3) != 0);
            bus.thrst = 9'($urandom_range(0, 511));
            if ($urandom_range(0, 1) == 0) begin
                bus.d_ptch = 16'($urandom); bus.ptch = 16'($urandom);
                bus.d_roll = 16'($urandom); bus.roll = 16'($urandom);
                bus.d_yaw  = 16'($urandom); bus.yaw  = 16'($urandom);
            end else begin
                set_err(int'($urandom_range(0, 600)) - 300, int'($urandom_range(0, 600)) - 300,
                        int'($urandom_range(0, 600)) - 300);
            end
            if (c == 3500) begin
                #3;
                rst_n = 1'b0;
                #1;
                chk("async_rst.state", int'(bus.fsm_state), 0);
                chk("async_rst.spd_vld", int'(bus.spd_vld), 0);
                chk_spd("async_rst", 0, 0, 0, 0);
                model_reset();
                @(posedge clk);
                #1;
                rst_n = 1'b1;
            end else begin
                cyc();
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
